// File: rtl/boa_arbiter_pkg.sv
// Shared arbitration types and the round-robin pick helper used by boa arbiters.
package boa_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int unsigned RR_MAX_PORTS = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req_mask scanning from prio upward, wrapping at nports.
    // prio must be < nports; indices >= nports are never returned.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_PORTS-1:0] req_mask,
                                         input logic [2:0]              prio,
                                         input int unsigned             nports);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
            if (!r.found && i < nports) begin
                j = {29'b0, prio} + i;
                if (j >= nports) j = j - nports;
                if (req_mask[j[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/boa_mem_bus_mux.sv
// Combinational select of one requester bus onto the target, with ready/rdata fan-out.
module boa_mem_bus_mux #(
    parameter int unsigned alen  = 32,
    parameter int unsigned ports = 2,
    parameter int unsigned sw    = 1
) (
    input  logic [sw-1:0]         sel,
    input  logic                  drive,
    input  logic [ports-1:0]      req_re,
    input  logic [4*ports-1:0]    req_we,
    input  logic [alen*ports-1:0] req_addr,
    input  logic [32*ports-1:0]   req_wdata,
    output logic [32*ports-1:0]   req_rdata,
    output logic [ports-1:0]      req_ready,
    output logic                  mem_re,
    output logic [3:0]            mem_we,
    output logic [alen-1:0]       mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    // Route the selected requester to the target; ready only back to that requester.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_ready = '0;
        req_rdata = {ports{mem_rdata}};
        for (int unsigned i = 0; i < ports; i++) begin
            if (drive && sel == sw'(i)) begin
                mem_re       = req_re[i];
                mem_we       = req_we[4*i +: 4];
                mem_addr     = req_addr[alen*i +: alen];
                mem_wdata    = req_wdata[32*i +: 32];
                req_ready[i] = mem_ready;
            end
        end
    end

endmodule

// File: rtl/boa_mem_rr_arbiter.sv
// Round-robin N:1 arbiter for one boa_mem_bus target with transaction-atomic
// grants and a bounded burst lock for back-to-back beats from one owner.
module boa_mem_rr_arbiter
    import boa_arbiter_pkg::*;
#(
    parameter int unsigned alen      = 32,
    parameter int unsigned ports     = 2,
    parameter int unsigned max_burst = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ports-1:0]           req_re,
    input  logic [4*ports-1:0]         req_we,
    input  logic [alen*ports-1:0]      req_addr,
    input  logic [32*ports-1:0]        req_wdata,
    output logic [32*ports-1:0]        req_rdata,
    output logic [ports-1:0]           req_ready,
    output logic                       mem_re,
    output logic [3:0]                 mem_we,
    output logic [alen-1:0]            mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ready,
    output logic [$clog2(ports)-1:0]   owner,
    output logic                       busy
);

    localparam int unsigned iw = $clog2(ports);
    localparam int unsigned cw = $clog2(max_burst + 1);
    localparam logic [cw:0] burst_lim = max_burst[cw:0];

    arb_state_t              state, state_nx;
    logic [iw-1:0]           prio, prio_nx, prio_eff, owner_nx, sel;
    logic [cw-1:0]           burst_cnt, cnt_nx, cnt_eff, cnt_base;
    logic [cw:0]             cnt_inc;
    logic [ports-1:0]        req_active;
    logic [RR_MAX_PORTS-1:0] mask8;
    rr_pick_t                pick;
    logic                    hold_lapsed, drive, done;

    function automatic logic [iw-1:0] next_idx(input logic [iw-1:0] p);
        return (p == iw'(ports - 1)) ? '0 : p + 1'b1;
    endfunction

    // A requester is active when it reads or writes any byte lane.
    always_comb begin
        req_active = '0;
        for (int unsigned i = 0; i < ports; i++)
            req_active[i] = req_re[i] | (|req_we[4*i +: 4]);
        mask8 = '0;
        mask8[ports-1:0] = req_active;
    end

    // Next-state, grant select and priority/burst bookkeeping.
    // A kept priority is only provisional: if the burst holder is not requesting
    // in the IDLE cycle that follows, priority rotates before this cycle's pick.
    always_comb begin
        state_nx    = state;
        prio_nx     = prio;
        cnt_nx      = burst_cnt;
        owner_nx    = owner;
        sel         = owner;
        drive       = 1'b0;
        done        = 1'b0;
        hold_lapsed = (state == ARB_IDLE) && (burst_cnt != '0) && !req_active[prio];
        prio_eff    = hold_lapsed ? next_idx(prio) : prio;
        cnt_eff     = hold_lapsed ? '0 : burst_cnt;
        cnt_base    = burst_cnt;
        pick        = rr_pick(mask8, 3'(prio_eff), ports);

        unique case (state)
            ARB_IDLE: begin
                prio_nx  = prio_eff;
                cnt_nx   = cnt_eff;
                cnt_base = cnt_eff;
                if (pick.found) begin
                    sel      = iw'(pick.idx);
                    drive    = 1'b1;
                    owner_nx = iw'(pick.idx);
                    if (mem_ready) done = 1'b1;
                    else           state_nx = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                drive = 1'b1;
                if (mem_ready) begin
                    done     = 1'b1;
                    state_nx = ARB_IDLE;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase

        cnt_inc = {1'b0, cnt_base} + 1'b1;
        if (done) begin
            if (cnt_inc < burst_lim) begin
                prio_nx = sel;
                cnt_nx  = cnt_inc[cw-1:0];
            end else begin
                prio_nx = next_idx(sel);
                cnt_nx  = '0;
            end
        end

        if (rst) drive = 1'b0;
    end

    // State, priority, burst count and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            prio      <= '0;
            burst_cnt <= '0;
            owner     <= '0;
        end else begin
            state     <= state_nx;
            prio      <= prio_nx;
            burst_cnt <= cnt_nx;
            owner     <= owner_nx;
        end
    end

    // The owner must hold its request until the target signals ready.
    always_ff @(posedge clk) begin
        if (!rst && state == ARB_BUSY && !mem_ready)
            assert (req_active[owner]);
    end

    assign busy = (state == ARB_BUSY);

    boa_mem_bus_mux #(
        .alen  (alen),
        .ports (ports),
        .sw    (iw)
    ) u_mux (
        .sel       (sel),
        .drive     (drive),
        .req_re    (req_re),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

endmodule

// File: tb/tb_boa_mem_rr_arbiter.sv
// Directed bench for boa_mem_rr_arbiter: a 3-port/burst-4 instance and a
// 2-port/burst-1 (pure round-robin) instance.
module tb_boa_mem_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 3 ports, max_burst 4
    logic        rst_a;
    logic [2:0]  a_re, a_ready;
    logic [11:0] a_we;
    logic [95:0] a_addr, a_wdata, a_rdata;
    logic        a_mre, a_mready, a_busy;
    logic [3:0]  a_mwe;
    logic [31:0] a_maddr, a_mwdata, a_mrdata;
    logic [1:0]  a_owner;

    // 2 ports, max_burst 1
    logic        rst_b;
    logic [1:0]  b_re, b_ready;
    logic [7:0]  b_we;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic        b_mre, b_mready, b_busy;
    logic [3:0]  b_mwe;
    logic [31:0] b_maddr, b_mwdata, b_mrdata;
    logic [0:0]  b_owner;

    boa_mem_rr_arbiter #(.alen(32), .ports(3), .max_burst(4)) dut_a (
        .clk(clk), .rst(rst_a),
        .req_re(a_re), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_rdata(a_rdata), .req_ready(a_ready),
        .mem_re(a_mre), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata), .mem_ready(a_mready),
        .owner(a_owner), .busy(a_busy)
    );

    boa_mem_rr_arbiter #(.alen(32), .ports(2), .max_burst(1)) dut_b (
        .clk(clk), .rst(rst_b),
        .req_re(b_re), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_rdata(b_rdata), .req_ready(b_ready),
        .mem_re(b_mre), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(b_mrdata), .mem_ready(b_mready),
        .owner(b_owner), .busy(b_busy)
    );

    int exp_port [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int beats0, n0, n1, n, ph, p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic a_idle();
        a_re = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        a_mready = 1'b0; a_mrdata = '0;
    endtask

    task automatic b_idle();
        b_re = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        b_mready = 1'b0; b_mrdata = '0;
    endtask

    task automatic reset_a();
        step();
        rst_a = 1'b1;
        a_idle();
        step();
        rst_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_idle(); b_idle();
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;
        settle();
        chk("rst_busy_a", a_busy, 0);
        chk("rst_owner_a", a_owner, 0);
        chk("rst_mre_a", a_mre, 0);
        chk("rst_mwe_a", a_mwe, 0);
        chk("rst_busy_b", b_busy, 0);
        chk("rst_owner_b", b_owner, 0);

        // Test 1: single read, target ready in the same cycle
        step();
        a_re[0] = 1'b1; a_addr[31:0] = 32'h8000_0010;
        a_mready = 1'b1; a_mrdata = 32'h1234_5678;
        settle();
        chk("t1_mre", a_mre, 1);
        chk("t1_maddr", a_maddr, 32'h8000_0010);
        chk("t1_ready", a_ready, 3'b001);
        chk("t1_rdata", a_rdata[31:0], 32'h1234_5678);
        chk("t1_busy", a_busy, 0);
        step();
        a_idle();
        settle();
        chk("t1_busy_after", a_busy, 0);
        chk("t1_owner", a_owner, 0);
        chk("t1_mre_idle", a_mre, 0);
        chk("t1_maddr_idle", a_maddr, 0);

        // Test 2: pure round-robin, both ports always requesting, 3-cycle txns
        n0 = 0; n1 = 0;
        for (int c = 0; c < 12; c++) begin
            n = c / 3; ph = c % 3; p = n % 2;
            b_re = 2'b11;
            b_addr[31:0]  = 32'hA000_0000 + n0;
            b_addr[63:32] = 32'hB000_0000 + n1;
            b_mready = (ph == 2);
            b_mrdata = 32'hCAFE_0000 + c;
            settle();
            chk("t2_maddr", b_maddr, (p == 0) ? 32'hA000_0000 + n0 : 32'hB000_0000 + n1);
            chk("t2_ready", b_ready, (ph == 2) ? (32'd1 << p) : 32'd0);
            chk("t2_busy", b_busy, (ph != 0) ? 32'd1 : 32'd0);
            if (ph != 0) chk("t2_owner", b_owner, p);
            if (ph == 2) begin
                if (p == 0) n0++;
                else        n1++;
            end
            step();
        end
        b_idle();

        // Test 3: req0 streams 8 beats while req1 waits for one txn
        reset_a();
        beats0 = 0;
        for (int c = 0; c < 9; c++) begin
            a_re[0] = 1'b1;
            a_addr[31:0] = 32'h100 + beats0;
            a_re[1] = (c <= 4);
            a_addr[63:32] = 32'h200;
            a_mready = 1'b1;
            a_mrdata = 32'h5000 + c;
            settle();
            chk("t3_ready", a_ready, 32'd1 << exp_port[c]);
            chk("t3_maddr", a_maddr, (exp_port[c] == 0) ? 32'h100 + beats0 : 32'h200);
            chk("t3_busy", a_busy, 0);
            chk("t3_owner", a_owner, (c == 0) ? 0 : exp_port[c-1]);
            if (exp_port[c] == 0) beats0++;
            step();
        end
        a_idle();
        settle();
        chk("t3_owner_end", a_owner, 0);

        // Test 4: reset pulse in the middle of a req1 write
        reset_a();
        a_we[7:4] = 4'b1111; a_addr[63:32] = 32'hC000_0000; a_wdata[63:32] = 32'hDEAD_BEEF;
        settle();
        chk("t4_mwe_grant", a_mwe, 4'b1111);
        chk("t4_maddr", a_maddr, 32'hC000_0000);
        chk("t4_mwdata", a_mwdata, 32'hDEAD_BEEF);
        step();
        settle();
        chk("t4_busy", a_busy, 1);
        chk("t4_owner_busy", a_owner, 1);
        step();
        rst_a = 1'b1;
        settle();
        chk("t4_mwe_rst", a_mwe, 0);
        chk("t4_ready_rst", a_ready, 0);
        step();
        rst_a = 1'b0;
        settle();
        chk("t4_busy_post", a_busy, 0);
        chk("t4_owner_post", a_owner, 0);
        chk("t4_mwe_reissue", a_mwe, 4'b1111);
        chk("t4_ready_wait", a_ready, 0);
        step();
        a_mready = 1'b1;
        settle();
        chk("t4_busy2", a_busy, 1);
        chk("t4_owner2", a_owner, 1);
        chk("t4_ready_done", a_ready, 3'b010);
        step();
        a_idle();
        settle();
        chk("t4_busy_end", a_busy, 0);

        // Test 5: req2 alone, then req0 and req2 together with priority back at 0
        reset_a();
        a_re[2] = 1'b1; a_addr[95:64] = 32'h310; a_mready = 1'b1;
        settle();
        chk("t5_ready_r2", a_ready, 3'b100);
        chk("t5_maddr_r2", a_maddr, 32'h310);
        step();
        a_idle();
        settle();
        chk("t5_ready_gap", a_ready, 0);
        chk("t5_mre_gap", a_mre, 0);
        step();
        a_re[0] = 1'b1; a_addr[31:0] = 32'h300;
        a_re[2] = 1'b1; a_addr[95:64] = 32'h320;
        settle();
        chk("t5_maddr_both", a_maddr, 32'h300);
        chk("t5_ready_wait", a_ready, 0);
        step();
        a_mready = 1'b1;
        settle();
        chk("t5_busy", a_busy, 1);
        chk("t5_owner", a_owner, 0);
        chk("t5_ready_r0", a_ready, 3'b001);
        step();
        a_re[0] = 1'b0;
        settle();
        chk("t5_maddr_r2b", a_maddr, 32'h320);
        chk("t5_ready_r2b", a_ready, 3'b100);
        chk("t5_busy_r2b", a_busy, 0);
        step();
        a_idle();
        settle();
        chk("t5_ready_end", a_ready, 0);
        chk("t5_owner_end", a_owner, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
